nearest_hit_sequencer: RTL and testbench

Parametrised per-pixel ray/object sequencer for the ray-tracing pipeline. It replaces the fixed 4-sphere, 2-cycle-per-sphere control sequence with an N-object, fully pipelined issue loop. It accepts one ray job, issues object indices to the object register file and collision unit, and reduces the returned hits to the nearest one. It then hands {hit, index, distance} to the pixel writer through a valid/ready handshake.

---
 rtl/ray_pkg.sv | 19 +
 rtl/nearest_hit_tag_pipe.sv | 46 ++++
 rtl/nearest_hit_sequencer.sv | 142 ++++++++++++++
 tb/tb_nearest_hit_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared ray-tracing pipeline types: fixed-point distance, miss sentinel and
// the sequencer state encoding.
package ray_pkg;

  localparam int FIXED_REAL_W = 64;

  typedef logic [FIXED_REAL_W-1:0] fixed_real;

  // All-ones distance doubles as "no hit" marker
  localparam fixed_real MISS_DIST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/nearest_hit_tag_pipe.sv
// DEPTH-deep {valid, index} delay line. The tap at DEPTH qualifies results of a
// fixed-latency lookup; empty reports that nothing is queued behind the tap.
module nearest_hit_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_index,
  output logic             tap_valid,
  output logic [IDX_W-1:0] tap_index,
  output logic             empty
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] index_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) index_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      index_q[0] <= in_index;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        index_q[i] <= index_q[i-1];
      end
    end
  end

  assign tap_valid = valid_q[DEPTH-1];
  assign tap_index = index_q[DEPTH-1];

  // The tap retires this cycle, so only upstream stages and the input matter:
  // once they are idle the line holds nothing after the next edge.
  generate
    if (DEPTH == 1) begin : g_single
      assign empty = !in_valid;
    end else begin : g_multi
      assign empty = !in_valid && (valid_q[DEPTH-2:0] == '0);
    end
  endgenerate

endmodule

// File: rtl/nearest_hit_sequencer.sv
// Per-pixel ray/object sequencer: issues NUM_OBJ object indices, reduces the
// returned hits to the nearest one and hands it out on a valid/ready port.
// Optional per-job object masking is enabled with the OBJ_MASK_EN macro.
module nearest_hit_sequencer
  import ray_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  parameter int DIST_W  = 64,
  parameter int COL_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Ray_valid,
  output logic              Ray_ready,
  output logic [IDX_W-1:0]  Read_index,
  output logic              Issue_valid,
  input  logic              Collision,
  input  logic [DIST_W-1:0] Curr_Dist,
`ifdef OBJ_MASK_EN
  input  logic [NUM_OBJ-1:0] Obj_mask,
`endif
  output logic              Pix_valid,
  input  logic              Pix_ready,
  output logic              Pix_hit,
  output logic [IDX_W-1:0]  Pix_index,
  output logic [DIST_W-1:0] Pix_dist,
  output seq_state_t        dbg_state
);

  // Handshakes: a transfer happens on a rising Clk edge where valid and ready
  // are both high. Ray_ready depends only on state; Pix_valid, once high, holds
  // with stable Pix_* until Pix_ready is seen.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              accept;
  logic [DIST_W-1:0] best_dist_q;
  logic [IDX_W-1:0]  best_idx_q;

  logic              tag_valid;
  logic [IDX_W-1:0]  tag_index;
  logic              tag_empty;
  logic              obj_en;
  logic              update;

  always_comb begin
    state_d     = state_q;
    Ray_ready   = 1'b0;
    Issue_valid = 1'b0;
    Pix_valid   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        Ray_ready = 1'b1;
        if (Ray_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        Issue_valid = 1'b1;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_empty) state_d = OUTPUT;
      end
      OUTPUT: begin
        Pix_valid = 1'b1;
        if (Pix_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Index counter wraps to 0 after the last object so the next job starts clean
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q <= '0;
    end else if (Issue_valid) begin
      if (idx_q == LAST_IDX) idx_q <= '0;
      else                   idx_q <= idx_q + 1'b1;
    end
  end

  assign Read_index = idx_q;

  nearest_hit_tag_pipe #(
    .DEPTH (COL_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .in_valid  (Issue_valid),
    .in_index  (Read_index),
    .tap_valid (tag_valid),
    .tap_index (tag_index),
    .empty     (tag_empty)
  );

`ifdef OBJ_MASK_EN
  logic [NUM_OBJ-1:0] mask_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    mask_q <= '0;
    else if (accept) mask_q <= Obj_mask;
  end

  assign obj_en = mask_q[tag_index];
`else
  assign obj_en = 1'b1;
`endif

  // Strict less-than with ascending issue order keeps the lower index on ties
  assign update = tag_valid && Collision && obj_en && (Curr_Dist < best_dist_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      best_dist_q <= '1;
      best_idx_q  <= '0;
    end else if (accept) begin
      best_dist_q <= '1;
      best_idx_q  <= '0;
    end else if (update) begin
      best_dist_q <= Curr_Dist;
      best_idx_q  <= tag_index;
    end
  end

  assign Pix_hit   = (best_dist_q != {DIST_W{1'b1}});
  assign Pix_index = best_idx_q;
  assign Pix_dist  = best_dist_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nearest_hit_sequencer.sv
// Self-checking bench for nearest_hit_sequencer: a 4-object/2-latency instance
// and an 8-object/3-latency instance, each fed by a collision-unit responder.
module tb_nearest_hit_sequencer;
  import ray_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- DUT (NUM_OBJ=4, COL_LAT=2) ----------------
  logic        ray_valid, ray_ready, issue_valid, collision;
  logic [1:0]  read_index, pix_index;
  logic [63:0] curr_dist, pix_dist;
  logic        pix_valid, pix_ready, pix_hit;
  seq_state_t  dbg_state;
`ifdef OBJ_MASK_EN
  logic [3:0]  obj_mask;
`endif

  nearest_hit_sequencer #(.NUM_OBJ(4), .DIST_W(64), .COL_LAT(2)) u_dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Ray_valid   (ray_valid),
    .Ray_ready   (ray_ready),
    .Read_index  (read_index),
    .Issue_valid (issue_valid),
    .Collision   (collision),
    .Curr_Dist   (curr_dist),
`ifdef OBJ_MASK_EN
    .Obj_mask    (obj_mask),
`endif
    .Pix_valid   (pix_valid),
    .Pix_ready   (pix_ready),
    .Pix_hit     (pix_hit),
    .Pix_index   (pix_index),
    .Pix_dist    (pix_dist),
    .dbg_state   (dbg_state)
  );

  // ---------------- DUT (NUM_OBJ=8, COL_LAT=3) ----------------
  logic        ray_valid8, ray_ready8, issue_valid8, collision8;
  logic [2:0]  read_index8, pix_index8;
  logic [63:0] curr_dist8, pix_dist8;
  logic        pix_valid8, pix_ready8, pix_hit8;
  seq_state_t  dbg_state8;
`ifdef OBJ_MASK_EN
  logic [7:0]  obj_mask8;
`endif

  nearest_hit_sequencer #(.NUM_OBJ(8), .DIST_W(64), .COL_LAT(3)) u_dut8 (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Ray_valid   (ray_valid8),
    .Ray_ready   (ray_ready8),
    .Read_index  (read_index8),
    .Issue_valid (issue_valid8),
    .Collision   (collision8),
    .Curr_Dist   (curr_dist8),
`ifdef OBJ_MASK_EN
    .Obj_mask    (obj_mask8),
`endif
    .Pix_valid   (pix_valid8),
    .Pix_ready   (pix_ready8),
    .Pix_hit     (pix_hit8),
    .Pix_index   (pix_index8),
    .Pix_dist    (pix_dist8),
    .dbg_state   (dbg_state8)
  );

  // ---------------- scene and collision responders ----------------
  logic        s_hit  [8];
  logic [63:0] s_dist [8];
  logic        s_mask [8];

  logic       h4_v [3];
  logic [1:0] h4_i [3];
  logic       h8_v [4];
  logic [2:0] h8_i [4];

  // Each entry k holds the issue seen k cycles ago; idle slots drive a bogus
  // close hit so an unqualified update would be visible.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin h4_v[k] = 1'b0; h4_i[k] = '0; end
    end else begin
      for (int k = 2; k > 0; k--) begin h4_v[k] = h4_v[k-1]; h4_i[k] = h4_i[k-1]; end
      h4_v[0] = issue_valid;
      h4_i[0] = read_index;
    end
    if (h4_v[2]) begin
      collision = s_hit[h4_i[2]];
      curr_dist = s_dist[h4_i[2]];
    end else begin
      collision = 1'b1;
      curr_dist = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin h8_v[k] = 1'b0; h8_i[k] = '0; end
    end else begin
      for (int k = 3; k > 0; k--) begin h8_v[k] = h8_v[k-1]; h8_i[k] = h8_i[k-1]; end
      h8_v[0] = issue_valid8;
      h8_i[0] = read_index8;
    end
    if (h8_v[3]) begin
      collision8 = s_hit[h8_i[3]];
      curr_dist8 = s_dist[h8_i[3]];
    end else begin
      collision8 = 1'b1;
      curr_dist8 = '0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [72:0] exp_q[$];
  logic [72:0] exp8_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: nearest enabled hit, ties to lower index, all-ones means miss
  function automatic logic [72:0] nearest(input int n);
    logic [63:0] best;
    logic [7:0]  bidx;
    best = '1;
    bidx = '0;
    for (int i = 0; i < n; i++) begin
      if (s_hit[i] && s_mask[i] && (s_dist[i] < best)) begin
        best = s_dist[i];
        bidx = 8'(i);
      end
    end
    return {(best != 64'hFFFF_FFFF_FFFF_FFFF), bidx, best};
  endfunction

  task automatic clear_scene();
    for (int i = 0; i < 8; i++) begin
      s_hit[i]  = 1'b0;
      s_dist[i] = '0;
      s_mask[i] = 1'b1;
    end
  endtask

  task automatic set_hit(input int i, input logic [63:0] d);
    s_hit[i]  = 1'b1;
    s_dist[i] = d;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic ready_level);
    @(negedge clk);
    check("ray_ready_idle", 80'(ray_ready), 80'(1));
    pix_ready = ready_level;
    ray_valid = 1'b1;
`ifdef OBJ_MASK_EN
    for (int i = 0; i < 4; i++) obj_mask[i] = s_mask[i];
`endif
    exp_q.push_back(nearest(4));
    @(posedge clk);
  endtask

  // Cycle 1 is the first cycle after acceptance
  task automatic wait_result(input int exp_lat, input int hold);
    logic [72:0] exp;
    bit seen;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) ray_valid = 1'b0;
      check("issue_valid", 80'(issue_valid), 80'(c <= 4));
      if (c <= 4) check("read_index", 80'(read_index), 80'(c - 1));
      if (pix_valid) begin
        seen = 1'b1;
        check("latency", 80'(c), 80'(exp_lat));
        exp = exp_q.pop_front();
        check("result", 80'({pix_hit, 8'(pix_index), pix_dist}), 80'(exp));
        if (hold > 0) begin
          ray_valid = 1'b1;
          for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable",
                  80'({pix_valid, ray_ready, issue_valid, pix_hit, 8'(pix_index), pix_dist}),
                  80'({3'b100, exp}));
          end
        end
        pix_ready = 1'b1;
      end
    end
    if (!seen) check("timeout", 80'(0), 80'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [72:0] exp8;
    bit any_pv;
    bit seen8;

    rst_n      = 1'b0;
    ray_valid  = 1'b0;
    pix_ready  = 1'b1;
    ray_valid8 = 1'b0;
    pix_ready8 = 1'b1;
    clear_scene();
`ifdef OBJ_MASK_EN
    obj_mask  = '1;
    obj_mask8 = '1;
`endif
    repeat (2) @(negedge clk);

    // reset state
    check("rst_state", 80'(dbg_state), 80'(IDLE));
    check("rst_outputs",
          80'({ray_ready, issue_valid, read_index, pix_valid, pix_hit, pix_index}),
          80'(8'b1000_0000));
    check("rst_pix_dist", 80'(pix_dist), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    rst_n = 1'b1;

    // all objects miss
    clear_scene();
    start_job(1'b1);
    wait_result(7, 0);

    // nearest of two hits
    clear_scene();
    set_hit(1, 64'h500);
    set_hit(3, 64'h200);
    start_job(1'b1);
    wait_result(7, 0);

    // tie goes to the lower index
    clear_scene();
    set_hit(0, 64'h100);
    set_hit(2, 64'h100);
    start_job(1'b1);
    wait_result(7, 0);

    // backpressure with Ray_valid held, then immediate re-accept
    clear_scene();
    set_hit(2, 64'h42);
    start_job(1'b0);
    wait_result(7, 10);
    exp_q.push_back(nearest(4));
    @(negedge clk);
    check("idle_after_release", 80'({ray_ready, pix_valid}), 80'(2'b10));
    @(posedge clk);
    wait_result(7, 0);

    // reset in the middle of a job
    clear_scene();
    set_hit(1, 64'h33);
    start_job(1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) ray_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_state", 80'(dbg_state), 80'(IDLE));
    check("midrst_outputs",
          80'({ray_ready, issue_valid, read_index, pix_valid, pix_hit, pix_index}),
          80'(8'b1000_0000));
    check("midrst_pix_dist", 80'(pix_dist), 80'(64'hFFFF_FFFF_FFFF_FFFF));
    @(negedge clk);
    rst_n = 1'b1;
    any_pv = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (pix_valid) any_pv = 1'b1;
    end
    check("no_pix_after_reset", 80'(any_pv), 80'(0));

    // cold start after reset
    start_job(1'b1);
    wait_result(7, 0);

    // random scenes with small distances to provoke ties
    for (int r = 0; r < 6; r++) begin
      clear_scene();
      for (int i = 0; i < 4; i++) begin
        s_hit[i]  = 1'($urandom_range(0, 1));
        s_dist[i] = 64'($urandom_range(1, 8));
      end
      start_job(1'b1);
      wait_result(7, 0);
    end

`ifdef OBJ_MASK_EN
    // masked-out hit never counts
    clear_scene();
    s_mask[1] = 1'b0;
    set_hit(1, 64'h10);
    start_job(1'b1);
    check("mask_model_miss", 80'(exp_q[0][72]), 80'(0));
    wait_result(7, 0);
`endif

    // 8 objects, latency 3, hit only on the last object
    clear_scene();
    set_hit(7, 64'h77);
    @(negedge clk);
    check("ray_ready8_idle", 80'(ray_ready8), 80'(1));
    ray_valid8 = 1'b1;
    exp8_q.push_back(nearest(8));
    @(posedge clk);
    seen8 = 1'b0;
    for (int c = 1; c <= 40 && !seen8; c++) begin
      @(negedge clk);
      if (c == 1) ray_valid8 = 1'b0;
      if (c <= 8) check("read_index8", 80'({issue_valid8, read_index8}), 80'({1'b1, 3'(c - 1)}));
      if (pix_valid8) begin
        seen8 = 1'b1;
        check("latency8", 80'(c), 80'(12));
        exp8 = exp8_q.pop_front();
        check("result8", 80'({pix_hit8, 8'(pix_index8), pix_dist8}), 80'(exp8));
        check("index8", 80'(pix_index8), 80'(7));
      end
    end
    if (!seen8) check("timeout8", 80'(0), 80'(1));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
